// File: rtl/imem_port_arbiter.sv
// Two-port round-robin arbiter sharing a single-port instruction memory.
// One transaction in flight at a time; a watchdog aborts stalled grant or response phases.
module imem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  s_req_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  input  logic                  s_gnt_i,
  input  logic                  s_rvalid_i,
  input  logic [DATA_WIDTH-1:0] s_rdata_i,
  output logic                  err_o,
  output logic                  err_id_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_WAIT = 2'd1,
    R_WAIT   = 2'd2
  } state_e;

  state_e                state_q;
  logic                  owner_q;
  logic                  last_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  err_q;
  logic                  err_id_q;

  logic winner_c;
  logic wd_hit_c;
  logic gnt_c;
  logic rvalid_c;

  // On a tie the port that did not win last time goes next.
  assign winner_c = (m0_req_i && m1_req_i) ? ~last_q : m1_req_i;
  assign wd_hit_c = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign gnt_c    = (state_q == GNT_WAIT) && s_gnt_i;
  assign rvalid_c = (state_q == R_WAIT) && s_rvalid_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
      err_id_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (m0_req_i || m1_req_i) begin
            owner_q <= winner_c;
            last_q  <= winner_c;
            addr_q  <= winner_c ? m1_addr_i : m0_addr_i;
            cnt_q   <= '0;
            state_q <= GNT_WAIT;
          end
        end
        GNT_WAIT: begin
          if (s_gnt_i) begin
            cnt_q   <= '0;
            state_q <= R_WAIT;
          end else if (wd_hit_c) begin
            err_q    <= 1'b1;
            err_id_q <= owner_q;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        R_WAIT: begin
          if (s_rvalid_i) begin
            state_q <= IDLE;
          end else if (wd_hit_c) begin
            err_q    <= 1'b1;
            err_id_q <= owner_q;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Grant and response are steered to the owner in the same cycle the memory signals them.
  assign s_req_o     = (state_q == GNT_WAIT);
  assign s_addr_o    = addr_q;
  assign m0_gnt_o    = gnt_c & ~owner_q;
  assign m1_gnt_o    = gnt_c & owner_q;
  assign m0_rvalid_o = rvalid_c & ~owner_q;
  assign m1_rvalid_o = rvalid_c & owner_q;
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;
  assign err_o       = err_q;
  assign err_id_o    = err_id_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: arbitration order, routing, watchdog, stray responses, reset.
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_i, m1_req_i;
  logic [7:0]  m0_addr_i, m1_addr_i;
  logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        s_req_o;
  logic [7:0]  s_addr_o;
  logic        s_gnt_i, s_rvalid_i;
  logic [31:0] s_rdata_i;
  logic        err_o, err_id_o;

  int n_vec = 0;
  int n_err = 0;

  imem_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_gnt_o(m1_gnt_o),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_gnt_i(s_gnt_i),
    .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
    .err_o(err_o), .err_id_o(err_id_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to the next cycle; inputs are driven 2 time units after the edge.
  task automatic step_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_gnt"},    32'({m1_gnt_o, m0_gnt_o}), 32'd0);
    chk({tag, "_rvalid"}, 32'({m1_rvalid_o, m0_rvalid_o}), 32'd0);
  endtask

  // Entry: current cycle is IDLE with requests already driven. Exit: IDLE cycle after rvalid.
  task automatic txn(input logic own, input logic [7:0] addr, input int gd, input int rd,
                     input logic [31:0] data);
    logic [1:0] onehot;
    onehot = own ? 2'b10 : 2'b01;
    #1;
    chk("idle_sreq", 32'(s_req_o), 32'd0);
    step_cyc();
    for (int i = 0; i < gd; i++) begin
      #1;
      chk("gw_sreq", 32'(s_req_o), 32'd1);
      chk("gw_gnt", 32'({m1_gnt_o, m0_gnt_o}), 32'd0);
      step_cyc();
    end
    s_gnt_i = 1'b1;
    #1;
    chk("s_addr", 32'(s_addr_o), 32'(addr));
    chk("gnt_route", 32'({m1_gnt_o, m0_gnt_o}), 32'(onehot));
    step_cyc();
    s_gnt_i = 1'b0;
    if (own) m1_req_i = 1'b0; else m0_req_i = 1'b0;
    for (int i = 0; i < rd; i++) begin
      #1;
      chk("rw_sreq", 32'(s_req_o), 32'd0);
      chk("rw_rvalid", 32'({m1_rvalid_o, m0_rvalid_o}), 32'd0);
      step_cyc();
    end
    s_rvalid_i = 1'b1;
    s_rdata_i  = data;
    #1;
    chk("rw_sreq", 32'(s_req_o), 32'd0);
    chk("rvalid_route", 32'({m1_rvalid_o, m0_rvalid_o}), 32'(onehot));
    chk("rdata", own ? m1_rdata_o : m0_rdata_o, data);
    step_cyc();
    s_rvalid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    s_gnt_i = 1'b0; s_rvalid_i = 1'b0;
    step_cyc();
    step_cyc();
    rst = 1'b0;
  endtask

  initial begin
    m0_addr_i = 8'h00; m1_addr_i = 8'h00; s_rdata_i = 32'h0;
    #2;
    do_reset();

    // Reset state
    #1;
    chk("rst_sreq", 32'(s_req_o), 32'd0);
    chk("rst_saddr", 32'(s_addr_o), 32'd0);
    chk("rst_err", 32'({err_o, err_id_o}), 32'd0);
    chk_idle_outs("rst");

    // Single port 0 fetch with 2-cycle grant and response latency
    m0_req_i = 1'b1; m0_addr_i = 8'h08;
    txn(1'b0, 8'h08, 2, 2, 32'h401101B3);

    // Tie after reset: port 0, then port 1, then port 0 again
    do_reset();
    m0_req_i = 1'b1; m0_addr_i = 8'h00;
    m1_req_i = 1'b1; m1_addr_i = 8'h80;
    txn(1'b0, 8'h00, 0, 0, 32'h11111111);
    txn(1'b1, 8'h80, 0, 0, 32'h22222222);
    m0_req_i = 1'b1; m1_req_i = 1'b1;
    txn(1'b0, 8'h00, 0, 0, 32'h33333333);

    // Sustained contention: last winner was port 0, so port 1 leads the alternation
    for (int i = 0; i < 8; i++) begin
      m0_req_i = 1'b1; m0_addr_i = 8'(8'h10 + i);
      m1_req_i = 1'b1; m1_addr_i = 8'h90;
      if (i % 2 == 0) txn(1'b1, 8'h90, 0, 1, 32'hA0000000 + 32'(i));
      else            txn(1'b0, 8'(8'h10 + i), 1, 0, 32'hB0000000 + 32'(i));
    end
    m0_req_i = 1'b0; m1_req_i = 1'b0;

    // Watchdog in GNT_WAIT: port 1 requests, memory never grants
    m1_req_i = 1'b1; m1_addr_i = 8'h5C;
    step_cyc();
    for (int i = 0; i < 15; i++) begin
      step_cyc();
      #1;
      if (i == 14) begin
        chk("gwto_last_sreq", 32'(s_req_o), 32'd1);
        chk("gwto_early_err", 32'(err_o), 32'd0);
      end
    end
    step_cyc();
    #1;
    chk("gwto_err", 32'(err_o), 32'd1);
    chk("gwto_err_id", 32'(err_id_o), 32'd1);
    chk("gwto_sreq", 32'(s_req_o), 32'd0);
    chk_idle_outs("gwto");
    step_cyc();
    #1;
    chk("gwto_pulse", 32'(err_o), 32'd0);
    chk("gwto_rearb", 32'(s_req_o), 32'd1);
    chk("gwto_addr", 32'(s_addr_o), 32'h5C);

    // Grant the re-arbitrated request, then starve the response
    s_gnt_i = 1'b1;
    #1;
    chk("rwto_gnt", 32'({m1_gnt_o, m0_gnt_o}), 32'd2);
    step_cyc();
    s_gnt_i = 1'b0; m1_req_i = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step_cyc();
      #1;
      if (i == 14) chk("rwto_early_err", 32'(err_o), 32'd0);
    end
    step_cyc();
    #1;
    chk("rwto_err", 32'(err_o), 32'd1);
    chk("rwto_err_id", 32'(err_id_o), 32'd1);
    chk_idle_outs("rwto");
    step_cyc();
    #1;
    chk("rwto_pulse", 32'(err_o), 32'd0);
    chk("rwto_idle", 32'(s_req_o), 32'd0);

    // Stray memory response and grant while IDLE
    s_rvalid_i = 1'b1; s_gnt_i = 1'b1; s_rdata_i = 32'hDEADBEEF;
    #1;
    chk_idle_outs("stray");
    step_cyc();
    s_rvalid_i = 1'b0; s_gnt_i = 1'b0;
    #1;
    chk("stray_sreq", 32'(s_req_o), 32'd0);

    // Reset during R_WAIT, late response must be dropped
    m1_req_i = 1'b1; m1_addr_i = 8'hE4;
    step_cyc();
    s_gnt_i = 1'b1;
    step_cyc();
    s_gnt_i = 1'b0; m1_req_i = 1'b0;
    rst = 1'b1;
    step_cyc();
    rst = 1'b0;
    s_rvalid_i = 1'b1; s_rdata_i = 32'hCAFEF00D;
    #1;
    chk_idle_outs("rstmid");
    chk("rstmid_sreq", 32'(s_req_o), 32'd0);
    chk("rstmid_saddr", 32'(s_addr_o), 32'd0);
    chk("rstmid_err", 32'(err_o), 32'd0);
    step_cyc();
    s_rvalid_i = 1'b0;
    m0_req_i = 1'b1; m0_addr_i = 8'h44;
    m1_req_i = 1'b1; m1_addr_i = 8'hC4;
    txn(1'b0, 8'h44, 0, 0, 32'h0BADF00D);
    m1_req_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
